t03_dpu_frame_sync: RTL

Frame-synchronous update scheduler between the CPU-side MMIO write path and the display-parameter register block. It absorbs CPU writes to the status word (game/player state, health) and the position word (x1/x2/y1/y2) into shadow registers at any time. At each vertical-blank rising edge it replays only the pending words, one per cycle, on the addr/data bus feeding the display register block. The displayed frame therefore never mixes old and new game state.

---
 rtl/t03_dpu_frame_sync.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/t03_dpu_frame_sync.sv
// ---------------------------------------------------------------------------
// t03_dpu_frame_sync
//
// Frame-synchronous update scheduler between the CPU MMIO write path and the
// display-parameter register block. CPU writes to the status word and the
// position word are absorbed into shadow registers at any time. On each rising
// edge of vblank the pending words are replayed, one per cycle, on the
// out_addr/out_data bus. A displayed frame therefore never mixes old and new
// game state.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   req_valid      CPU write request
//   req_addr[31:0] CPU write address
//   req_data[31:0] CPU write data
//   req_ready      high when a request can be accepted (IDLE only)
//   vblank         vertical-blank level, synchronous to clk
//   out_addr[31:0] registered address to the display block, 0 when idle
//   out_data[31:0] registered data to the display block, 0 when idle
//   busy           high while a commit burst is in progress
//   overwrite_cnt  saturating count of writes replacing an uncommitted value
// ---------------------------------------------------------------------------
module t03_dpu_frame_sync (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        req_ready,
    input  logic        vblank,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic [7:0]  overwrite_cnt
);

    localparam logic [31:0] STATUS_ADDR = 32'hFF00_0003;
    localparam logic [31:0] POS_ADDR    = 32'hFF00_0004;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE_ST  = 2'd1,
        ISSUE_POS = 2'd2
    } state_t;

    state_t      state, state_next;

    logic [15:0] status_sh;
    logic [31:0] pos_sh;
    logic        st_pend, pos_pend;
    logic [15:0] snap_st;
    logic [31:0] snap_pos;
    logic        snap_has_pos;   // the burst in flight includes the position word
    logic        vblank_q;

    logic        accept, hit_st, hit_pos, commit;
    logic [31:0] addr_next, data_next;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign accept  = req_valid && req_ready;
    assign hit_st  = accept && (req_addr == STATUS_ADDR);
    assign hit_pos = accept && (req_addr == POS_ADDR);

    // Next-state and next bus value. At the commit edge the snapshot is not
    // loaded yet, so the first word is taken from the shadow (same value).
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        addr_next  = 32'h0;
        data_next  = 32'h0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (vblank && !vblank_q && (st_pend || pos_pend)) begin
                    commit = 1'b1;
                    if (st_pend) begin
                        addr_next  = STATUS_ADDR;
                        data_next  = {16'h0, status_sh};
                        state_next = ISSUE_ST;
                    end else begin
                        addr_next  = POS_ADDR;
                        data_next  = pos_sh;
                        state_next = ISSUE_POS;
                    end
                end
            end
            ISSUE_ST: begin
                if (snap_has_pos) begin
                    addr_next  = POS_ADDR;
                    data_next  = snap_pos;
                    state_next = ISSUE_POS;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE_POS: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            out_addr      <= 32'h0;
            out_data      <= 32'h0;
            status_sh     <= 16'h0;
            pos_sh        <= 32'h0;
            st_pend       <= 1'b0;
            pos_pend      <= 1'b0;
            snap_st       <= 16'h0;
            snap_pos      <= 32'h0;
            snap_has_pos  <= 1'b0;
            vblank_q      <= 1'b0;
            overwrite_cnt <= 8'h0;
        end else begin
            state    <= state_next;
            out_addr <= addr_next;
            out_data <= data_next;
            vblank_q <= vblank;

            // Snapshot takes the pre-edge shadow; a write accepted on the same
            // edge lands in the shadow afterwards and stays pending.
            if (commit) begin
                snap_st      <= status_sh;
                snap_pos     <= pos_sh;
                snap_has_pos <= pos_pend;
            end

            if (hit_st) begin
                status_sh <= req_data[15:0];
                st_pend   <= 1'b1;
            end else if (commit) begin
                st_pend   <= 1'b0;
            end

            if (hit_pos) begin
                pos_sh   <= req_data;
                pos_pend <= 1'b1;
            end else if (commit) begin
                pos_pend <= 1'b0;
            end

            if (((hit_st && st_pend) || (hit_pos && pos_pend)) &&
                (overwrite_cnt != 8'hFF)) begin
                overwrite_cnt <= overwrite_cnt + 8'd1;
            end
        end
    end

endmodule
